// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: FSM state encoding, M-unit opcode fields, response record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_state_t;

    // R-type custom encoding used by the M-unit (MUL/DIV family)
    localparam logic [6:0] OPCODE_CUSTOM = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL        = 3'd0;
    localparam logic [2:0] F3_DIV        = 3'd4;
    localparam logic [2:0] F3_DIVU       = 3'd5;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic        illegal;
    } pcpi_rsp_t;

endpackage

// File: rtl/pcpi_timeout_counter.sv
// Counts consecutive idle issue cycles; expired flags the last allowed cycle.
// Latency: expired is a decode of the registered count (no input path).
// Backpressure: n/a; saturates at TIMEOUT_CYCLES-1 and never wraps.
module pcpi_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Clear dominates; increment only while below the saturation point
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/pcpi_issuer.sv
// Issues one custom instruction to the PCPI coprocessor bus and returns its result.
// Latency: pcpi_valid one cycle after accept; rsp_valid one cycle after pcpi_ready or expiry.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module pcpi_issuer
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_illegal,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_busy
);
    pcpi_state_t state, state_next;
    pcpi_rsp_t   rsp;
    logic [31:0] insn_q, rs1_q, rs2_q;

    logic accept;
    logic cap_result;
    logic cap_timeout;
    logic cnt_clear;
    logic cnt_enable;
    logic expired;

    pcpi_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(expired)
    );

    // Next-state and capture decisions; pcpi_* inputs only matter in ISSUE
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        cap_result  = 1'b0;
        cap_timeout = 1'b0;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pcpi_ready) begin
                    // A result arriving on the expiry cycle still counts as legal
                    cap_result = 1'b1;
                    state_next = RESP;
                end else if (pcpi_busy) begin
                    cnt_clear = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                    if (expired) begin
                        cap_timeout = 1'b1;
                        state_next  = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, held stable for the whole issue phase
    always_ff @(posedge clk) begin
        if (rst) begin
            insn_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (accept) begin
            insn_q <= req_insn;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
        end
    end

    // Response capture: coprocessor result or illegal-instruction marker
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp <= '0;
        end else if (cap_result) begin
            rsp <= '{wr: pcpi_wr, rd: pcpi_rd, illegal: 1'b0};
        end else if (cap_timeout) begin
            rsp <= '{wr: 1'b0, rd: 32'h0, illegal: 1'b1};
        end
    end

    // Handshake outputs decode the registered state only
    assign req_ready   = (state == IDLE);
    assign pcpi_valid  = (state == ISSUE);
    assign rsp_valid   = (state == RESP);

    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign rsp_wr      = rsp.wr;
    assign rsp_rd      = rsp.rd;
    assign rsp_illegal = rsp.illegal;

endmodule
